frame_packer: RTL and testbench

Packs the triggered, gain-selected sample stream from `data_trigger` into framed AXI4-Stream packets for the DMA path.
- Each contiguous run of `S_AXIS_TVALID` (one trigger segment) becomes one frame: a header word followed by the segment's data words, with TLAST on the last data word.
- An internal FIFO absorbs downstream back-pressure, because the upstream stream has no TREADY.
- A frame is admitted only if it is guaranteed to fit in the FIFO; otherwise the whole segment is dropped and counted.

---
 rtl/frame_packer.sv | 138 +++++++++++++
 tb/tb_frame_packer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/frame_packer.sv
// Packs each contiguous S_AXIS_TVALID segment into a header word plus data words,
// buffered in an internal FIFO so the TREADY-less upstream never has to stall.
`timescale 1ns/1ps
module frame_packer #(
  parameter logic [7:0] CHANNEL_ID      = 8'd0,
  parameter int         MAX_FRAME_WORDS = 64,
  parameter int         FIFO_DEPTH      = 128
)(
  input  logic         ACLK,
  input  logic         ARESET,
  input  logic [215:0] S_AXIS_TDATA,
  input  logic         S_AXIS_TVALID,
  output logic [127:0] M_AXIS_TDATA,
  output logic         M_AXIS_TVALID,
  input  logic         M_AXIS_TREADY,
  output logic         M_AXIS_TLAST,
  output logic         M_AXIS_TUSER,
  output logic [15:0]  DROPPED_FRAME_COUNT,
  output logic [15:0]  TRUNCATED_FRAME_COUNT
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = AW + 1;
  localparam int CW = $clog2(MAX_FRAME_WORDS + 1);
  localparam logic [FW-1:0] ADMIT_MAX = FW'(FIFO_DEPTH - MAX_FRAME_WORDS - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(MAX_FRAME_WORDS - 1);

  typedef enum logic [1:0] {IDLE, STREAM, DISCARD} state_t;

  state_t        state;
  logic [127:0]  hold_data;
  logic          hold_user;
  logic [CW-1:0] cnt;
  logic [15:0]   seq;

  // fill counts FIFO entries plus the output register, so a stalled word still occupies space
  logic [FW-1:0] fill;
  logic [AW-1:0] wptr, rptr;
  logic [129:0]  mem [FIFO_DEPTH];
  logic          wr_en, pop, xfer, admit, last_word, mem_empty;
  logic [129:0]  wr_word;

  wire [127:0] in_data = S_AXIS_TDATA[215:88];
  wire [7:0]   in_info = S_AXIS_TDATA[87:80];
  wire [47:0]  in_ts   = S_AXIS_TDATA[79:32];
  wire [31:0]  in_cfg  = S_AXIS_TDATA[31:0];

  assign admit     = fill <= ADMIT_MAX;
  assign last_word = !S_AXIS_TVALID || (cnt == CNT_LAST);
  assign mem_empty = fill == {{(FW-1){1'b0}}, M_AXIS_TVALID};
  assign xfer      = M_AXIS_TVALID && M_AXIS_TREADY;
  assign pop       = !mem_empty && (!M_AXIS_TVALID || M_AXIS_TREADY);

  // Entry layout: {tuser, tlast, tdata}
  always_comb begin
    wr_en   = 1'b0;
    wr_word = '0;
    case (state)
      IDLE: if (S_AXIS_TVALID && admit) begin
        wr_en   = 1'b1;
        wr_word = {2'b00, 8'hAA, CHANNEL_ID, in_info, in_ts, in_cfg, seq, 8'h00};
      end
      STREAM: begin
        wr_en   = 1'b1;
        wr_word = {hold_user, last_word, hold_data};
      end
      default: ;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state                 <= IDLE;
      hold_data             <= '0;
      hold_user             <= 1'b0;
      cnt                   <= '0;
      seq                   <= '0;
      DROPPED_FRAME_COUNT   <= '0;
      TRUNCATED_FRAME_COUNT <= '0;
    end else begin
      case (state)
        IDLE: if (S_AXIS_TVALID) begin
          seq <= seq + 16'd1;
          if (admit) begin
            hold_data <= in_data;
            hold_user <= in_info[4];
            cnt       <= '0;
            state     <= STREAM;
          end else begin
            if (DROPPED_FRAME_COUNT != 16'hFFFF)
              DROPPED_FRAME_COUNT <= DROPPED_FRAME_COUNT + 16'd1;
            state <= DISCARD;
          end
        end
        STREAM: begin
          hold_data <= in_data;
          hold_user <= in_info[4];
          cnt       <= cnt + 1'b1;
          // an end of segment coinciding with the limit is a normal end
          if (!S_AXIS_TVALID)
            state <= IDLE;
          else if (cnt == CNT_LAST) begin
            if (TRUNCATED_FRAME_COUNT != 16'hFFFF)
              TRUNCATED_FRAME_COUNT <= TRUNCATED_FRAME_COUNT + 16'd1;
            state <= DISCARD;
          end
        end
        DISCARD: if (!S_AXIS_TVALID) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (wr_en) mem[wptr] <= wr_word;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wptr          <= '0;
      rptr          <= '0;
      fill          <= '0;
      M_AXIS_TVALID <= 1'b0;
      M_AXIS_TDATA  <= '0;
      M_AXIS_TLAST  <= 1'b0;
      M_AXIS_TUSER  <= 1'b0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (pop)   rptr <= rptr + 1'b1;
      fill <= fill + FW'(wr_en) - FW'(xfer);
      if (pop) begin
        M_AXIS_TVALID <= 1'b1;
        {M_AXIS_TUSER, M_AXIS_TLAST, M_AXIS_TDATA} <= mem[rptr];
      end else if (xfer) begin
        M_AXIS_TVALID <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_frame_packer.sv
// Scoreboard bench: a default-sized packer and a small one (MAX 4, depth 8) side by side.
`timescale 1ns/1ps
module tb_frame_packer;
  logic ACLK = 1'b0;
  logic ARESET;
  always #5 ACLK = ~ACLK;

  logic [215:0] s_tdata   [2];
  logic         s_tvalid  [2];
  logic         m_tready  [2];
  logic [127:0] m_tdata   [2];
  logic         m_tvalid  [2];
  logic         m_tlast   [2];
  logic         m_tuser   [2];
  logic [15:0]  dropped   [2];
  logic [15:0]  truncated [2];

  frame_packer #(.CHANNEL_ID(8'h5A)) u_big (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXIS_TDATA(s_tdata[0]), .S_AXIS_TVALID(s_tvalid[0]),
    .M_AXIS_TDATA(m_tdata[0]), .M_AXIS_TVALID(m_tvalid[0]), .M_AXIS_TREADY(m_tready[0]),
    .M_AXIS_TLAST(m_tlast[0]), .M_AXIS_TUSER(m_tuser[0]),
    .DROPPED_FRAME_COUNT(dropped[0]), .TRUNCATED_FRAME_COUNT(truncated[0]));

  frame_packer #(.CHANNEL_ID(8'h3C), .MAX_FRAME_WORDS(4), .FIFO_DEPTH(8)) u_small (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXIS_TDATA(s_tdata[1]), .S_AXIS_TVALID(s_tvalid[1]),
    .M_AXIS_TDATA(m_tdata[1]), .M_AXIS_TVALID(m_tvalid[1]), .M_AXIS_TREADY(m_tready[1]),
    .M_AXIS_TLAST(m_tlast[1]), .M_AXIS_TUSER(m_tuser[1]),
    .DROPPED_FRAME_COUNT(dropped[1]), .TRUNCATED_FRAME_COUNT(truncated[1]));

  int n_cmp = 0, n_err = 0, cyc = 0;
  int seq_m [2];
  int hdr_cyc [2];
  logic rnd_rdy = 1'b0;
  // entry: {is_header, tuser, tlast, tdata}
  logic [130:0] exp_q0 [$];
  logic [130:0] exp_q1 [$];
  logic         prev_stall [2];
  logic [129:0] prev_w [2];

  always @(posedge ACLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [129:0] obs, input logic [129:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic int qsize(input int i);
    return (i == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic void push(input int i, input logic [130:0] w);
    if (i == 0) exp_q0.push_back(w); else exp_q1.push_back(w);
  endfunction

  task automatic tick();
    @(posedge ACLK); #1;
  endtask

  // One segment of n beats followed by exactly one idle cycle
  task automatic send(input int i, input int n, input logic [7:0] info, input logic [47:0] ts,
                      input logic [31:0] cfg, input bit drop, input int maxw, output int t0);
    logic [127:0] d;
    logic [7:0]   ik, ch;
    logic [15:0]  s;
    int nw;
    nw = (n < maxw) ? n : maxw;
    ch = (i == 0) ? 8'h5A : 8'h3C;
    s  = 16'(seq_m[i]);
    t0 = 0;
    if (!drop) push(i, {1'b1, 2'b00, 8'hAA, ch, info, ts, cfg, s, 8'h00});
    seq_m[i] = (seq_m[i] + 1) & 16'hFFFF;
    for (int k = 0; k < n; k++) begin
      d  = {$urandom, $urandom, $urandom, $urandom};
      ik = (k == 0) ? info : (8'($urandom) | (info & 8'h10));
      if (!drop && k < nw) push(i, {1'b0, ik[4], (k == nw - 1), d});
      s_tdata[i]  = {d, ik, ts, cfg};
      s_tvalid[i] = 1'b1;
      if (k == 0) t0 = cyc;
      tick();
    end
    s_tvalid[i] = 1'b0;
    s_tdata[i]  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    tick();
  endtask

  task automatic drain(input string tag, input int budget);
    for (int c = 0; c < budget; c++) begin
      if (qsize(0) == 0 && qsize(1) == 0) break;
      tick();
    end
    chk(tag, qsize(0) + qsize(1), 0);
    tick(); tick();
  endtask

  always @(posedge ACLK) if (rnd_rdy) begin
    #1 m_tready[0] = 1'($urandom_range(0, 1));
  end

  always @(negedge ACLK) begin
    for (int i = 0; i < 2; i++) begin
      logic [129:0] w;
      logic [130:0] e;
      w = {m_tuser[i], m_tlast[i], m_tdata[i]};
      if (ARESET) prev_stall[i] = 1'b0;
      else begin
        if (prev_stall[i]) begin
          chk("stall_valid", m_tvalid[i], 1'b1);
          chk("stall_word", w, prev_w[i]);
        end
        if (m_tvalid[i] && m_tready[i]) begin
          e = {1'b0, 2'b11, 128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0};
          if (qsize(i) != 0) e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          chk(i == 0 ? "word_big" : "word_small", w, e[129:0]);
          if (e[130]) hdr_cyc[i] = cyc;
        end
        prev_stall[i] = m_tvalid[i] && !m_tready[i];
        prev_w[i]     = w;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0;
    ARESET = 1'b1;
    for (int i = 0; i < 2; i++) begin
      s_tvalid[i] = 1'b0; s_tdata[i] = '0; m_tready[i] = 1'b1;
      seq_m[i] = 0; hdr_cyc[i] = 0; prev_stall[i] = 1'b0; prev_w[i] = '0;
    end
    repeat (3) tick();
    for (int i = 0; i < 2; i++) begin
      chk("rst_tvalid", m_tvalid[i], 1'b0);
      chk("rst_dropped", dropped[i], 16'd0);
      chk("rst_truncated", truncated[i], 16'd0);
    end
    ARESET = 1'b0;
    tick();

    // single 3-beat segment, header latency
    send(0, 3, 8'h13, 48'h123456789ABC, 32'hC0FFEE01, 1'b0, 64, t0);
    drain("drain_single", 50);
    chk("hdr_latency", hdr_cyc[0], t0 + 2);

    // back-to-back 2-beat segments separated by one idle cycle
    send(0, 2, 8'h02, 48'h0000AAAA5555, 32'h11111111, 1'b0, 64, t0);
    send(0, 2, 8'h17, 48'h0000BBBB6666, 32'h22222222, 1'b0, 64, t0);
    drain("drain_b2b", 50);

    // truncation, then exactly-MAX boundary, then a 1-beat segment
    send(1, 10, 8'h10, 48'hFEDCBA987654, 32'h33333333, 1'b0, 4, t0);
    drain("drain_trunc", 50);
    chk("trunc_count", truncated[1], 16'd1);
    send(1, 4, 8'h00, 48'h000000000004, 32'h44444444, 1'b0, 4, t0);
    send(1, 1, 8'h10, 48'h000000000001, 32'h55555555, 1'b0, 4, t0);
    drain("drain_exact", 50);
    chk("trunc_exact", truncated[1], 16'd1);

    // drop when the stalled FIFO cannot hold a full frame
    m_tready[1] = 1'b0;
    send(1, 3, 8'h05, 48'h00000000D0D0, 32'h66666666, 1'b0, 4, t0);
    send(1, 3, 8'h15, 48'h00000000D1D1, 32'h77777777, 1'b1, 4, t0);
    chk("drop_count", dropped[1], 16'd1);
    m_tready[1] = 1'b1;
    drain("drain_drop", 50);
    send(1, 2, 8'h08, 48'h00000000D2D2, 32'h88888888, 1'b0, 4, t0);
    drain("drain_after_drop", 50);
    chk("drop_hold", dropped[1], 16'd1);

    // full-length frame under random back-pressure
    rnd_rdy = 1'b1;
    send(0, 64, 8'h1F, 48'h0BADC0DE0000, 32'h99999999, 1'b0, 64, t0);
    drain("drain_bp", 2000);
    rnd_rdy = 1'b0;
    tick();
    m_tready[0] = 1'b1;
    chk("bp_no_trunc", truncated[0], 16'd0);

    // reset in the middle of a frame
    m_tready[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      s_tvalid[0] = 1'b1;
      s_tdata[0]  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      tick();
    end
    ARESET = 1'b1;
    s_tvalid[0] = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) begin
      chk("mid_rst_tvalid", m_tvalid[i], 1'b0);
      chk("mid_rst_dropped", dropped[i], 16'd0);
      chk("mid_rst_truncated", truncated[i], 16'd0);
      seq_m[i] = 0;
    end
    ARESET = 1'b0;
    m_tready[0] = 1'b1;
    repeat (5) tick();
    send(0, 2, 8'h11, 48'h00000000E0E0, 32'hAAAAAAAA, 1'b0, 64, t0);
    drain("drain_post_rst", 50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
